clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
User-interface sequencer for the HH:MM:SS timekeeper counter. It takes two raw push-buttons (MODE, INC) and walks the user through editing hours, minutes, then seconds. It commits the edited time to the timekeeper with a one-cycle load pulse and gates the timekeeper's run enable while editing. It sits between the board buttons and the timekeeper; its display-hint outputs feed the 7-segment driver.

Parameters:
CLOCK_FREQ, 50000000, CLK frequency in Hz; sets blink half-period to CLOCK_FREQ/2 cycles.
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a button level change.
REPEAT_DELAY_CYCLES, 25000000, INC held this long after its press pulse starts auto-repeat.
REPEAT_RATE_CYCLES, 5000000, auto-repeat period while INC remains held.
TIMEOUT_CYCLES, 500000000, idle cycles in an edit state before abandoning the edit.

Ports:
CLK  input  1  clock
RST  input  1  asynchronous, active-low reset
MODE_BTN  input  1  raw, asynchronous, active-high mode button
INC_BTN  input  1  raw, asynchronous, active-high increment button
cur_hours  input  8  timekeeper's current hours
cur_minutes  input  8  timekeeper's current minutes
cur_seconds  input  8  timekeeper's current seconds
run_en  output  1  1 = timekeeper may count
load_en  output  1  one-cycle pulse: timekeeper loads load_* values
load_hours  output  8  edited hours
load_minutes  output  8  edited minutes
load_seconds  output  8  edited seconds
edit_field  output  2  0 none, 1 hours, 2 minutes, 3 seconds
blink  output  1  display blink phase for the selected field

Behaviour:
- Reset (RST low, async): state RUN, run_en=1, load_en=0, load_*=0, edit_field=0, blink=0. All counters and synchronizers clear. Reset mid-edit discards edits; no load is issued.
- Button conditioning: 2-flop synchronizer, then debounce. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples. A press pulse (1 cycle) is emitted on each debounced rising edge. The held level is available to the FSM.
- States RUN, SET_H, SET_M, SET_S, COMMIT.
- RUN: run_en=1, edit_field=0. On a MODE pulse, capture cur_* into load_* and go to SET_H. Any captured value above its maximum (hours >23, min/sec >59) is captured as 0.
- SET_H/SET_M/SET_S: run_en=0, edit_field=1/2/3. A MODE pulse advances SET_H→SET_M→SET_S→COMMIT.
- COMMIT: lasts exactly 1 cycle. load_en=1 with the held load_*, then RUN. run_en returns to 1 in the cycle after COMMIT.
- Increment: in a SET state, an INC pulse adds 1 to the selected field. Hours wrap 23→0; minutes and seconds wrap 59→0. Fields are 8-bit binary.
- Auto-repeat: while INC is held, the repeat counter starts at the press pulse. After REPEAT_DELAY_CYCLES one increment fires, then one every REPEAT_RATE_CYCLES. Releasing INC clears the counter.
- Simultaneous events: a MODE pulse and an INC increment (pulse or repeat) in the same cycle → MODE wins, the increment is dropped, and the repeat counter clears.
- A state change also clears the repeat counter, so a held INC does not carry into the next field until a new press.
- Timeout: the idle counter clears on any MODE/INC pulse or repeat. After TIMEOUT_CYCLES with no such event in a SET state, return to RUN without load_en; edits are lost.
- Blink: toggles every CLOCK_FREQ/2 cycles in SET states; forced 0 in RUN and COMMIT. The blink counter restarts on entry to SET_H.
- load_* outputs hold their last values in RUN.

Decomposition:
- Package clock_pkg: state enum (RUN, SET_H, SET_M, SET_S, COMMIT), edit_field codes, MAX_HOURS=23, MAX_MINUTES=59, MAX_SECONDS=59.
- Sub-module button_conditioner(DEBOUNCE_CYCLES): sync, debounce, press pulse, held level. Instantiated twice.

Test Plan:
Bench parameters: CLOCK_FREQ=16, DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_RATE=5, TIMEOUT=200.
- MODE glitch of 2 cycles → no state change. Clean MODE press in RUN with cur=12:34:56 → SET_H, load=12:34:56, run_en=0, edit_field=1.
- In SET_H at 23, one INC press → hours=0. In SET_M at 59, one INC → minutes=0, hours unchanged.
- Full edit: MODE, INC×2, MODE, INC×1, MODE, MODE → one load_en pulse with 14:35:56, then run_en=1 and edit_field=0.
- INC held 40 cycles past its press pulse in SET_S from 10 → press +1, repeats at +20, +25, +30, +35 → seconds=15.
- Enter SET_H, idle 200 cycles → RUN, load_en never asserted. Separately, RST low mid-SET_M → RUN, all outputs at reset values.
- MODE and INC press pulses in the same cycle in SET_H → state SET_M, hours unchanged. cur=30:70:05 captured → load=00:00:05.

Source files
------------

// File: rtl/clock_set_controller_pkg.sv
// Shared types, field limits and small helpers for the clock-setting sequencer.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        FIELD_NONE    = 2'd0,
        FIELD_HOURS   = 2'd1,
        FIELD_MINUTES = 2'd2,
        FIELD_SECONDS = 2'd3
    } field_e;

    localparam logic [7:0] MAX_HOURS   = 8'd23;
    localparam logic [7:0] MAX_MINUTES = 8'd59;
    localparam logic [7:0] MAX_SECONDS = 8'd59;

    // Out-of-range timekeeper values are replaced by zero when captured.
    function automatic logic [7:0] clamp_field(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? 8'd0 : v;
    endfunction

    // Modulo increment of one time field.
    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max_v);
        return (v >= max_v) ? 8'd0 : (v + 8'd1);
    endfunction

    function automatic logic is_set_state(input state_e s);
        return (s == ST_SET_H) || (s == ST_SET_M) || (s == ST_SET_S);
    endfunction

    function automatic field_e field_of(input state_e s);
        field_e f;
        case (s)
            ST_SET_H: f = FIELD_HOURS;
            ST_SET_M: f = FIELD_MINUTES;
            ST_SET_S: f = FIELD_SECONDS;
            default:  f = FIELD_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Timekeeper-facing bus: current time in, run enable and load request out.
interface clock_set_controller_if;
    logic [7:0] cur_hours;
    logic [7:0] cur_minutes;
    logic [7:0] cur_seconds;
    logic       run_en;
    logic       load_en;
    logic [7:0] load_hours;
    logic [7:0] load_minutes;
    logic [7:0] load_seconds;

    modport master (
        input  cur_hours, cur_minutes, cur_seconds,
        output run_en, load_en, load_hours, load_minutes, load_seconds
    );

    modport slave (
        output cur_hours, cur_minutes, cur_seconds,
        input  run_en, load_en, load_hours, load_minutes, load_seconds
    );
endinterface

// File: rtl/clock_set_controller_button_conditioner.sv
// Raw push-button conditioning: 2-flop synchronizer, level debounce,
// one-cycle press pulse on each debounced rising edge, and held level.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_i,
    output logic pulse_o,
    output logic held_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous button into the CLK domain.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after a full run of differing samples.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                pulse_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pulse_o = pulse_q;
    assign held_o  = level_q;

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven HH:MM:SS editing sequencer in front of the timekeeper.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int CLOCK_FREQ          = 50000000,
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000,
    parameter int TIMEOUT_CYCLES      = 500000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    MODE_BTN,
    input  logic                    INC_BTN,
    clock_set_controller_if.master  tk,
    output logic [1:0]              edit_field,
    output logic                    blink
);

    localparam int BLINK_HALF = (CLOCK_FREQ / 2 > 0) ? (CLOCK_FREQ / 2) : 1;

    logic        mode_pulse_s, mode_held_unused_s;
    logic        inc_pulse_s, inc_held_s;

    state_e      state_q, state_d;
    logic [7:0]  hours_q, hours_d;
    logic [7:0]  minutes_q, minutes_d;
    logic [7:0]  seconds_q, seconds_d;
    logic [31:0] rpt_q, rpt_d;
    logic        rpt_rep_q, rpt_rep_d;
    logic [31:0] idle_q, idle_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        run_en_q, run_en_d;
    logic        load_en_q, load_en_d;
    field_e      field_q, field_d;

    logic        in_set_s, inc_fire_s, rpt_fire_s, event_s, timeout_s, state_change_s;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .CLK     (CLK),
        .RST     (RST),
        .btn_i   (MODE_BTN),
        .pulse_o (mode_pulse_s),
        .held_o  (mode_held_unused_s)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .CLK     (CLK),
        .RST     (RST),
        .btn_i   (INC_BTN),
        .pulse_o (inc_pulse_s),
        .held_o  (inc_held_s)
    );

    // rpt_q counts cycles since the press (or last repeat); zero means idle.
    assign in_set_s   = is_set_state(state_q);
    assign rpt_fire_s = in_set_s && inc_held_s && (rpt_q != 32'd0) &&
                        ((!rpt_rep_q && (rpt_q == 32'(REPEAT_DELAY_CYCLES))) ||
                         ( rpt_rep_q && (rpt_q == 32'(REPEAT_RATE_CYCLES))));
    assign inc_fire_s = inc_pulse_s || rpt_fire_s;
    assign event_s    = mode_pulse_s || inc_fire_s;
    assign timeout_s  = in_set_s && !event_s && (idle_q == 32'(TIMEOUT_CYCLES - 1));
    assign state_change_s = (state_d != state_q);

    // Next state and edited field values; MODE outranks any increment.
    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        case (state_q)
            ST_RUN: begin
                if (mode_pulse_s) begin
                    hours_d   = clamp_field(tk.cur_hours,   MAX_HOURS);
                    minutes_d = clamp_field(tk.cur_minutes, MAX_MINUTES);
                    seconds_d = clamp_field(tk.cur_seconds, MAX_SECONDS);
                    state_d   = ST_SET_H;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_H: begin
                if (mode_pulse_s)    state_d = ST_SET_M;
                else if (timeout_s)  state_d = ST_RUN;
                else if (inc_fire_s) hours_d = wrap_inc(hours_q, MAX_HOURS);
                else                 state_d = ST_SET_H;
            end
            ST_SET_M: begin
                if (mode_pulse_s)    state_d = ST_SET_S;
                else if (timeout_s)  state_d = ST_RUN;
                else if (inc_fire_s) minutes_d = wrap_inc(minutes_q, MAX_MINUTES);
                else                 state_d = ST_SET_M;
            end
            ST_SET_S: begin
                if (mode_pulse_s)    state_d = ST_COMMIT;
                else if (timeout_s)  state_d = ST_RUN;
                else if (inc_fire_s) seconds_d = wrap_inc(seconds_q, MAX_SECONDS);
                else                 state_d = ST_SET_S;
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Repeat, idle and blink counters plus registered output values.
    always_comb begin
        rpt_d       = rpt_q;
        rpt_rep_d   = rpt_rep_q;
        idle_d      = idle_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        if (!in_set_s || state_change_s || mode_pulse_s || !inc_held_s) begin
            rpt_d     = 32'd0;
            rpt_rep_d = 1'b0;
        end else if (inc_pulse_s) begin
            rpt_d     = 32'd1;
            rpt_rep_d = 1'b0;
        end else if (rpt_fire_s) begin
            rpt_d     = 32'd1;
            rpt_rep_d = 1'b1;
        end else if (rpt_q != 32'd0) begin
            rpt_d = rpt_q + 32'd1;
        end else begin
            rpt_d = 32'd0;
        end

        if (!in_set_s || state_change_s || event_s) begin
            idle_d = 32'd0;
        end else begin
            idle_d = idle_q + 32'd1;
        end

        if ((state_change_s && (state_d == ST_SET_H)) || !is_set_state(state_d)) begin
            blink_cnt_d = 32'd0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == 32'(BLINK_HALF - 1)) begin
            blink_cnt_d = 32'd0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 32'd1;
        end

        run_en_d  = (state_d == ST_RUN);
        load_en_d = (state_d == ST_COMMIT);
        field_d   = field_of(state_d);
    end

    // State, counters and outputs; reset discards any edit in progress.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_RUN;
            hours_q     <= 8'd0;
            minutes_q   <= 8'd0;
            seconds_q   <= 8'd0;
            rpt_q       <= 32'd0;
            rpt_rep_q   <= 1'b0;
            idle_q      <= 32'd0;
            blink_cnt_q <= 32'd0;
            blink_q     <= 1'b0;
            run_en_q    <= 1'b1;
            load_en_q   <= 1'b0;
            field_q     <= FIELD_NONE;
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            rpt_q       <= rpt_d;
            rpt_rep_q   <= rpt_rep_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            run_en_q    <= run_en_d;
            load_en_q   <= load_en_d;
            field_q     <= field_d;
        end
    end

    assign tk.run_en       = run_en_q;
    assign tk.load_en      = load_en_q;
    assign tk.load_hours   = hours_q;
    assign tk.load_minutes = minutes_q;
    assign tk.load_seconds = seconds_q;
    assign edit_field      = field_q;
    assign blink           = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed, table-driven bench for clock_set_controller.
module tb_clock_set_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic       MODE_BTN;
    logic       INC_BTN;
    logic [1:0] edit_field;
    logic       blink;

    clock_set_controller_if tk_if ();

    clock_set_controller #(
        .CLOCK_FREQ          (16),
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_RATE_CYCLES  (5),
        .TIMEOUT_CYCLES      (200)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MODE_BTN   (MODE_BTN),
        .INC_BTN    (INC_BTN),
        .tk         (tk_if),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       mode;
        logic       inc;
        logic [7:0] ch, cm, cs;
        logic [1:0] f;
        logic       run;
        logic [7:0] h, m, s;
        int         loads;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_err = 0;
    int load_cnt = 0;
    logic [7:0] last_lh = 8'd0, last_lm = 8'd0, last_ls = 8'd0;

    // Count load pulses and remember what was loaded.
    always @(posedge CLK) begin
        if (tk_if.load_en === 1'b1) begin
            load_cnt <= load_cnt + 1;
            last_lh  <= tk_if.load_hours;
            last_lm  <= tk_if.load_minutes;
            last_ls  <= tk_if.load_seconds;
        end
    end

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic m, input logic i);
        MODE_BTN = m;
        INC_BTN  = i;
        repeat (8) @(negedge CLK);
        MODE_BTN = 1'b0;
        INC_BTN  = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        tk_if.cur_hours   = h;
        tk_if.cur_minutes = m;
        tk_if.cur_seconds = s;
    endtask

    initial begin
        int base;
        int rises;
        logic prev_blink;

        vecs[0]  = '{1'b0, 1'b0, 8'd12, 8'd34, 8'd56, 2'd0, 1'b1, 8'd0,  8'd0,  8'd0,  0};
        vecs[1]  = '{1'b1, 1'b0, 8'd12, 8'd34, 8'd56, 2'd1, 1'b0, 8'd12, 8'd34, 8'd56, 0};
        vecs[2]  = '{1'b0, 1'b1, 8'd12, 8'd34, 8'd56, 2'd1, 1'b0, 8'd13, 8'd34, 8'd56, 0};
        vecs[3]  = '{1'b0, 1'b1, 8'd12, 8'd34, 8'd56, 2'd1, 1'b0, 8'd14, 8'd34, 8'd56, 0};
        vecs[4]  = '{1'b1, 1'b0, 8'd12, 8'd34, 8'd56, 2'd2, 1'b0, 8'd14, 8'd34, 8'd56, 0};
        vecs[5]  = '{1'b0, 1'b1, 8'd12, 8'd34, 8'd56, 2'd2, 1'b0, 8'd14, 8'd35, 8'd56, 0};
        vecs[6]  = '{1'b1, 1'b0, 8'd12, 8'd34, 8'd56, 2'd3, 1'b0, 8'd14, 8'd35, 8'd56, 0};
        vecs[7]  = '{1'b1, 1'b0, 8'd12, 8'd34, 8'd56, 2'd0, 1'b1, 8'd14, 8'd35, 8'd56, 1};
        vecs[8]  = '{1'b1, 1'b0, 8'd23, 8'd59, 8'd10, 2'd1, 1'b0, 8'd23, 8'd59, 8'd10, 0};
        vecs[9]  = '{1'b0, 1'b1, 8'd23, 8'd59, 8'd10, 2'd1, 1'b0, 8'd0,  8'd59, 8'd10, 0};
        vecs[10] = '{1'b1, 1'b0, 8'd23, 8'd59, 8'd10, 2'd2, 1'b0, 8'd0,  8'd59, 8'd10, 0};
        vecs[11] = '{1'b0, 1'b1, 8'd23, 8'd59, 8'd10, 2'd2, 1'b0, 8'd0,  8'd0,  8'd10, 0};
        vecs[12] = '{1'b1, 1'b0, 8'd23, 8'd59, 8'd10, 2'd3, 1'b0, 8'd0,  8'd0,  8'd10, 0};

        RST = 1'b0;
        MODE_BTN = 1'b0;
        INC_BTN  = 1'b0;
        set_cur(8'd12, 8'd34, 8'd56);
        repeat (3) @(negedge CLK);
        check("reset field", edit_field, 2'd0);
        check("reset run_en", tk_if.run_en, 1'b1);
        check("reset load_en", tk_if.load_en, 1'b0);
        check("reset load_h", tk_if.load_hours, 8'd0);
        check("reset blink", blink, 1'b0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        // Two-cycle MODE glitch must be rejected.
        MODE_BTN = 1'b1;
        repeat (2) @(negedge CLK);
        MODE_BTN = 1'b0;
        repeat (15) @(negedge CLK);
        check("glitch field", edit_field, 2'd0);
        check("glitch run_en", tk_if.run_en, 1'b1);

        for (int k = 0; k < NV; k++) begin
            set_cur(vecs[k].ch, vecs[k].cm, vecs[k].cs);
            base = load_cnt;
            press(vecs[k].mode, vecs[k].inc);
            check($sformatf("v%0d field", k), edit_field, vecs[k].f);
            check($sformatf("v%0d run_en", k), tk_if.run_en, vecs[k].run);
            check($sformatf("v%0d hours", k), tk_if.load_hours, vecs[k].h);
            check($sformatf("v%0d minutes", k), tk_if.load_minutes, vecs[k].m);
            check($sformatf("v%0d seconds", k), tk_if.load_seconds, vecs[k].s);
            check($sformatf("v%0d loads", k), load_cnt - base, vecs[k].loads);
            if (vecs[k].loads != 0) begin
                check($sformatf("v%0d loaded hms", k), {8'd0, last_lh, last_lm, last_ls},
                      {8'd0, vecs[k].h, vecs[k].m, vecs[k].s});
            end
        end

        // Auto-repeat in SET_S from 10: press +1, then +20/+25/+30/+35.
        INC_BTN = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            if (tk_if.load_seconds == 8'd11) break;
        end
        check("repeat first", tk_if.load_seconds, 8'd11);
        repeat (31) @(negedge CLK);
        INC_BTN = 1'b0;
        repeat (20) @(negedge CLK);
        check("repeat seconds", tk_if.load_seconds, 8'd15);
        check("repeat field", edit_field, 2'd3);
        base = load_cnt;
        press(1'b1, 1'b0);
        check("commit2 loads", load_cnt - base, 1);
        check("commit2 hms", {8'd0, last_lh, last_lm, last_ls}, {8'd0, 8'd0, 8'd0, 8'd15});
        check("commit2 field", edit_field, 2'd0);

        // Idle timeout in SET_H: back to RUN with no load.
        set_cur(8'd5, 8'd6, 8'd7);
        press(1'b1, 1'b0);
        check("to field", edit_field, 2'd1);
        base = load_cnt;
        rises = 0;
        prev_blink = blink;
        for (int t = 0; t < 170; t++) begin
            @(negedge CLK);
            if (blink && !prev_blink) rises++;
            prev_blink = blink;
        end
        check("to not yet", edit_field, 2'd1);
        check("to blink toggles", (rises > 0) ? 32'd1 : 32'd0, 32'd1);
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            if (edit_field == 2'd0) break;
        end
        check("to expired field", edit_field, 2'd0);
        check("to run_en", tk_if.run_en, 1'b1);
        check("to loads", load_cnt - base, 0);
        check("to blink", blink, 1'b0);

        // Out-of-range capture, then MODE+INC together.
        set_cur(8'd30, 8'd70, 8'd5);
        press(1'b1, 1'b0);
        check("clamp field", edit_field, 2'd1);
        check("clamp hms", {8'd0, tk_if.load_hours, tk_if.load_minutes, tk_if.load_seconds},
              {8'd0, 8'd0, 8'd0, 8'd5});
        press(1'b1, 1'b1);
        check("simul field", edit_field, 2'd2);
        check("simul hours", tk_if.load_hours, 8'd0);

        // Asynchronous reset mid-SET_M.
        base = load_cnt;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst field", edit_field, 2'd0);
        check("rst run_en", tk_if.run_en, 1'b1);
        check("rst hms", {8'd0, tk_if.load_hours, tk_if.load_minutes, tk_if.load_seconds}, 32'd0);
        check("rst blink", blink, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        check("rst after field", edit_field, 2'd0);
        check("rst loads", load_cnt - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
